// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Holds the FSM state encoding, the 64-bit word type and the default reset vector.
package pc_gen_pkg;

    typedef logic [63:0] u64;

    localparam u64 PC_RESET_VEC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_PEND = 2'd2
    } pcgen_state_t;

    // Mask that clears the low align_bits bits of a 64-bit address.
    function automatic u64 align_mask(input int unsigned align_bits);
        u64 ones;
        ones = (64'd1 << align_bits) - 64'd1;
        return ~ones;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector: channel 0 wins, the remaining channels are dropped.
// Purely combinational; the selected target is registered inside pc_gen.
module pc_redirect_arb #(
    parameter int XLEN    = 64,
    parameter int N_REDIR = 2
) (
    input  logic [N_REDIR-1:0]      i_redir_valid,
    input  logic [N_REDIR*XLEN-1:0] i_redir_pc,
    output logic                    o_any_redir,
    output logic [XLEN-1:0]         o_sel_pc
);

    // Walk from the lowest priority upward so the lowest valid index is written last.
    always_comb begin
        o_any_redir = |i_redir_valid;
        o_sel_pc    = '0;
        for (int k = N_REDIR - 1; k >= 0; k--) begin
            if (i_redir_valid[k]) begin
                o_sel_pc = i_redir_pc[k*XLEN +: XLEN];
            end else begin
                o_sel_pc = o_sel_pc;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: sequential step, prioritised redirect, freeze, held-redirect buffer.
// Optional macro PC_MISALIGN_CHECK_EN: keep targets unmasked and flag misaligned loads on misalign.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC),
    parameter int              N_REDIR    = 2,
    parameter int              INST_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    stallI,
    input  logic                    stallM,
    input  logic [N_REDIR-1:0]      redir_valid,
    input  logic [N_REDIR*XLEN-1:0] redir_pc,
    output logic [XLEN-1:0]         pc,
    output logic                    pc_valid,
    output logic                    redir_pending,
    output logic                    misalign
);

    localparam int              ALIGN      = $clog2(INST_BYTES);
    localparam u64              MASK64     = align_mask(ALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = MASK64[XLEN-1:0];
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

    pcgen_state_t    r_state;
    pcgen_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_nxt;
    logic            r_pc_valid;
    logic            r_redir_pending;
    logic            w_freeze;
    logic            w_any_redir;
    logic [XLEN-1:0] w_sel_pc;
    logic [XLEN-1:0] w_target;

    assign w_freeze = stall | stallI | stallM;

    pc_redirect_arb #(
        .XLEN    (XLEN),
        .N_REDIR (N_REDIR)
    ) u_arb (
        .i_redir_valid (redir_valid),
        .i_redir_pc    (redir_pc),
        .o_any_redir   (w_any_redir),
        .o_sel_pc      (w_sel_pc)
    );

`ifdef PC_MISALIGN_CHECK_EN
    assign w_target = w_sel_pc;
`else
    assign w_target = w_sel_pc & ALIGN_MASK;
`endif

    // Next-state, next-pc and held-redirect selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        case (r_state)
            PC_BOOT, PC_RUN: begin
                if (!w_freeze) begin
                    w_state_nxt = PC_RUN;
                    if (w_any_redir) begin
                        w_pc_nxt = w_target;
                    end else if (r_state == PC_RUN) begin
                        w_pc_nxt = r_pc + STEP;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                end else if (w_any_redir) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = PC_PEND;
                end else begin
                    w_state_nxt = PC_RUN;
                end
            end
            PC_PEND: begin
                if (!w_freeze) begin
                    w_state_nxt = PC_RUN;
                    if (w_any_redir) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pend_pc;
                    end
                end else if (w_any_redir) begin
                    w_pend_nxt = w_target;
                end else begin
                    w_pend_nxt = r_pend_pc;
                end
            end
            default: begin
                w_state_nxt = PC_BOOT;
                w_pc_nxt    = RESET_VEC;
            end
        endcase
    end

    // State, pc, held target and status flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= PC_BOOT;
            r_pc            <= RESET_VEC;
            r_pend_pc       <= '0;
            r_pc_valid      <= 1'b0;
            r_redir_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_pend_pc       <= w_pend_nxt;
            r_pc_valid      <= (w_state_nxt != PC_BOOT);
            r_redir_pending <= (w_state_nxt == PC_PEND);
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_nxt;
    logic w_load_tgt;

    // A target lands in pc on any unfrozen redirect or when the held one is released.
    assign w_load_tgt = !w_freeze && (w_any_redir || (r_state == PC_PEND));

    // Flag follows the loaded target, holds while frozen, clears on a sequential step.
    always_comb begin
        if (w_load_tgt) begin
            w_misalign_nxt = |(w_pc_nxt & ~ALIGN_MASK);
        end else if (w_freeze) begin
            w_misalign_nxt = r_misalign;
        end else begin
            w_misalign_nxt = 1'b0;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    assign pc            = r_pc;
    assign pc_valid      = r_pc_valid;
    assign redir_pending = r_redir_pending;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expected PCs.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_pc_gen;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         stallI;
    logic         stallM;
    logic [1:0]   redir_valid;
    logic [127:0] redir_pc;
    logic [63:0]  pc;
    logic         pc_valid;
    logic         redir_pending;
    logic         misalign;

    int n_cmp;
    int n_bad;

    pc_gen dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .stallI        (stallI),
        .stallM        (stallM),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .redir_pending (redir_pending),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1);
        redir_valid = v;
        redir_pc    = {p1, p0};
    endtask

    task automatic status(input string tag, input logic [63:0] e_pc, input logic e_v, input logic e_p);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".valid"}, {63'd0, pc_valid}, {63'd0, e_v});
        chk({tag, ".pend"}, {63'd0, redir_pending}, {63'd0, e_p});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        stall  = 1'b0;
        stallI = 1'b0;
        stallM = 1'b0;
        redir(2'b00, 64'd0, 64'd0);

        // 1: reset and boot sequence
        repeat (3) tick();
        status("rst", 64'h8000_0000, 1'b0, 1'b0);
        chk("rst.mis", {63'd0, misalign}, 64'd0);
        reset = 1'b1;
        status("boot", 64'h8000_0000, 1'b0, 1'b0);
        tick();
        status("run0", 64'h8000_0000, 1'b1, 1'b0);
        tick();
        status("run1", 64'h8000_0004, 1'b1, 1'b0);
        tick();
        status("run2", 64'h8000_0008, 1'b1, 1'b0);

        // 2: both channels, channel 0 wins
        redir(2'b11, 64'h8000_1000, 64'h8000_2000);
        tick();
        status("prio", 64'h8000_1000, 1'b1, 1'b0);

        // 3: redirect captured while imem busy, applied on unfreeze
        stallI = 1'b1;
        redir(2'b10, 64'd0, 64'h8000_3000);
        tick();
        status("frz1", 64'h8000_1000, 1'b1, 1'b1);
        redir(2'b00, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            status("frzN", 64'h8000_1000, 1'b1, 1'b1);
        end
        stallI = 1'b0;
        tick();
        status("unfrz", 64'h8000_3000, 1'b1, 1'b0);

        // 4: live redirect on unfreeze beats the held one
        stall = 1'b1;
        redir(2'b10, 64'd0, 64'h8000_3000);
        tick();
        status("pend4", 64'h8000_3000, 1'b1, 1'b1);
        stall = 1'b0;
        redir(2'b01, 64'h8000_4000, 64'd0);
        tick();
        status("live", 64'h8000_4000, 1'b1, 1'b0);
        redir(2'b00, 64'd0, 64'd0);
        tick();
        status("live+4", 64'h8000_4004, 1'b1, 1'b0);

        // freeze with no redirect holds pc and stays out of PEND
        stallM = 1'b1;
        tick();
        status("hold", 64'h8000_4004, 1'b1, 1'b0);
        stallM = 1'b0;
        tick();
        status("hold+4", 64'h8000_4008, 1'b1, 1'b0);

        // latest redirect while frozen overwrites the held one
        stall = 1'b1;
        redir(2'b10, 64'd0, 64'h8000_6000);
        tick();
        redir(2'b01, 64'h8000_7000, 64'd0);
        tick();
        status("ovw", 64'h8000_4008, 1'b1, 1'b1);
        stall = 1'b0;
        redir(2'b00, 64'd0, 64'd0);
        tick();
        status("ovw.rel", 64'h8000_7000, 1'b1, 1'b0);

        // 5: wrap at the top of the address space
        redir(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        tick();
        chk("top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        redir(2'b00, 64'd0, 64'd0);
        tick();
        chk("wrap", pc, 64'h0);
        tick();
        chk("wrap+4", pc, 64'h4);

        // 6: misaligned target
        redir(2'b01, 64'h8000_0002, 64'd0);
        tick();
`ifdef PC_MISALIGN_CHECK_EN
        chk("mis.pc", pc, 64'h8000_0002);
        chk("mis.flag", {63'd0, misalign}, 64'd1);
        redir(2'b00, 64'd0, 64'd0);
        tick();
        chk("mis.clr", {63'd0, misalign}, 64'd0);
`else
        chk("mis.pc", pc, 64'h8000_0000);
        chk("mis.flag", {63'd0, misalign}, 64'd0);
        redir(2'b00, 64'd0, 64'd0);
        tick();
        chk("mis.step", pc, 64'h8000_0004);
`endif

        // 7: async reset while a redirect is held
        stall = 1'b1;
        redir(2'b01, 64'h8000_5000, 64'd0);
        tick();
        chk("pre7.pend", {63'd0, redir_pending}, 64'd1);
        reset = 1'b0;
        #1;
        status("arst", 64'h8000_0000, 1'b0, 1'b0);
        stall = 1'b0;
        redir(2'b00, 64'd0, 64'd0);
        tick();
        reset = 1'b1;
        status("arst.boot", 64'h8000_0000, 1'b0, 1'b0);
        tick();
        status("arst.run", 64'h8000_0000, 1'b1, 1'b0);
        tick();
        status("arst.run1", 64'h8000_0004, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
